histogram_engine: RTL
=====================

Name: histogram_engine

Overview:
- Parametrised successor to the single-channel grey histogram.
- Accumulates per-bin pixel counts from the camera grey stream through a pipelined read-modify-write path with same-bin forwarding, so back-to-back identical pixels are counted correctly.
- Adds a hardware clear sweep, saturating bin counts, a frame total counter and an arbitrated readout port.
- Sits between the grey-conversion stage and the LCD histogram overlay/equalisation logic.

Parameters:
- PIX_W, 8, grey sample width; number of bins is NBINS = 2**PIX_W.
- CNT_W, 20, bin counter width; saturates at 2**CNT_W-1.
- TOT_W, 20, frame total counter width; saturates at 2**TOT_W-1.

Ports:
- iClk  in  1  system clock, all logic rising-edge.
- iRst_n  in  1  asynchronous active-low reset.
- iClear  in  1  single-cycle pulse; starts the clear sweep.
- iInc  in  1  pixel valid; increment bin iGray this cycle.
- iGray  in  PIX_W  pixel grey value (bin index).
- iRdEn  in  1  readout request.
- iRdAddr  in  PIX_W  bin to read.
- oRdValid  out  1  readout data valid.
- oGray  out  PIX_W  bin index of returned data.
- oGrayHisto  out  CNT_W  count of bin oGray.
- oTotal  out  TOT_W  pixels accepted since last clear.
- oBusy  out  1  clear sweep in progress.
- oSat  out  1  sticky: some bin saturated since last clear.

Behaviour:
- Reset (iRst_n=0, async): FSM=CLEAR, sweep address 0, oBusy=1, oRdValid=0, oGray=0, oGrayHisto=0, oTotal=0, oSat=0, pipeline valid bits 0. RAM contents are undefined until the post-reset sweep completes.
- FSM states IDLE, CLEAR.
  - CLEAR: write 0 to bin addr, addr++ each cycle; after bin NBINS-1 → IDLE. The sweep takes exactly NBINS cycles; oBusy drops the cycle after the last write.
  - IDLE: iClear=1 → CLEAR (addr=0, oTotal=0, oSat=0 on the same edge).
  - iClear while in CLEAR restarts the sweep at addr 0.
- During CLEAR, iInc and iRdEn are ignored (dropped; no oRdValid), and the pipeline is flushed.
- Accumulate pipeline (IDLE only), single synchronous-read dual-port RAM:
  - S0 (cycle N): iInc registers bin address and issues the RAM read.
  - S1 (cycle N+1): count = RAM data, or the forwarded value; next = count==max ? max : count+1; write next at cycle N+1.
  - Forwarding: if the S1 bin equals the bin written in the previous cycle, use that written value instead of RAM data. A run of k identical pixels therefore yields count k.
  - Saturation holds at 2**CNT_W-1 and sets oSat.
- oTotal increments for every accepted iInc, saturating at 2**TOT_W-1.
- Readout:
  - iRdEn at cycle N (IDLE and iInc=0): oRdValid=1, oGray=iRdAddr, oGrayHisto=count at N+1. The value includes all increments accepted up to cycle N-1, via forwarding from an in-flight write.
  - iRdEn and iInc in the same cycle: the increment wins, the read is dropped, and oRdValid stays 0 at N+1.
  - oRdValid is a one-cycle pulse per accepted read. oGray/oGrayHisto hold their last value otherwise.
- iClear coincident with iInc in IDLE: the clear wins; that pixel is dropped and does not count in oTotal.
- Pending S1 write when iClear arrives: the write completes at the same edge the sweep starts. The sweep then overwrites it, so all bins end at 0.

Decomposition:
- histogram_pkg: the FSM state enum (ST_IDLE, ST_CLEAR), NBINS derivation, saturating-max constants as functions of CNT_W/TOT_W.
- One sub-module: histogram_ram. Simple dual-port, NBINS x CNT_W, synchronous read with old-data-on-collision behaviour. It is inferable as block RAM; forwarding lives in the engine, not in the RAM.

Test Plan:
- Reset, then wait: oBusy=1 for exactly 256 cycles after release. Reading bins 0, 128 and 255 then returns 0 with oRdValid one cycle after iRdEn, and oTotal=0.
- Stream 1000 pixels of value 37 back-to-back: bin 37 reads 1000, bins 36 and 38 read 0, oTotal=1000 (forwarding check).
- Alternating stream 5,9,5,9… of 200 pixels plus pattern i%256 for 512 pixels: bins 5 and 9 read 102 each, every other bin reads 2, oTotal=712.
- CNT_W=4 build, 20 pixels of value 3: bin 3 reads 15, oSat=1. A subsequent iClear clears oSat, and bin 3 reads 0 after the sweep.
- iRdEn asserted together with iInc: no oRdValid follows. iRdEn the cycle after an increment of bin 7 (prior count 4) returns 5.
- iClear mid-stream, and again at sweep cycle 100: oBusy lasts 256 cycles from the second pulse, and iInc during the sweep leaves all bins and oTotal at 0.

Source files
------------

// File: rtl/histogram_pkg.sv
// Shared types and width-derived constants for the grey histogram engine.
package histogram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int unsigned nbins(input int unsigned pix_w);
    return 32'd1 << pix_w;
  endfunction

  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << w) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/histogram_engine_if.sv
// Pixel, clear and readout signals of the histogram engine, grouped as one bus.
interface histogram_engine_if #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20,
  parameter int TOT_W = 20
);
  logic             iClear;
  logic             iInc;
  logic [PIX_W-1:0] iGray;
  logic             iRdEn;
  logic [PIX_W-1:0] iRdAddr;
  logic             oRdValid;
  logic [PIX_W-1:0] oGray;
  logic [CNT_W-1:0] oGrayHisto;
  logic [TOT_W-1:0] oTotal;
  logic             oBusy;
  logic             oSat;

  modport master (
    output iClear, iInc, iGray, iRdEn, iRdAddr,
    input  oRdValid, oGray, oGrayHisto, oTotal, oBusy, oSat
  );

  modport slave (
    input  iClear, iInc, iGray, iRdEn, iRdAddr,
    output oRdValid, oGray, oGrayHisto, oTotal, oBusy, oSat
  );
endinterface

// File: rtl/histogram_ram.sv
// Simple dual-port bin store: one write port, one synchronous read port that
// returns the old contents when both ports hit the same address.
module histogram_ram #(
  parameter int AW = 8,
  parameter int DW = 20
) (
  input  logic          iClk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // No reset so the array maps onto block RAM; the engine sweeps it instead.
  always_ff @(posedge iClk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/histogram_engine.sv
// Per-bin pixel counter: read-modify-write over a block RAM with same-bin
// forwarding, hardware clear sweep, saturating counts and a readout port.
module histogram_engine
  import histogram_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20,
  parameter int TOT_W = 20
) (
  input logic               iClk,
  input logic               iRst_n,
  histogram_engine_if.slave bus
);
  localparam int unsigned      NBINS     = nbins(PIX_W);
  localparam logic [PIX_W-1:0] ADDR_LAST = PIX_W'(NBINS - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(sat_max(CNT_W));
  localparam logic [TOT_W-1:0] TOT_MAX   = TOT_W'(sat_max(TOT_W));

  state_t           r_state, w_state_nxt;
  logic [PIX_W-1:0] r_addr, w_addr_nxt;
  logic             w_inc_acc, w_rd_acc, w_clr;
  logic             w_we;
  logic [PIX_W-1:0] w_waddr, w_raddr;
  logic [CNT_W-1:0] w_wdata, w_rd_data, w_q, w_next;
  logic             w_fwd_hit;

  logic             r_s1_vld;
  logic [PIX_W-1:0] r_s1_addr;
  logic             r_fwd_vld;
  logic [CNT_W-1:0] r_fwd_data;
  logic             r_rd_vld;
  logic [PIX_W-1:0] r_gray;
  logic [CNT_W-1:0] r_histo_hold;
  logic [TOT_W-1:0] r_total;
  logic             r_sat;
  logic             r_busy;

  histogram_ram #(.AW(PIX_W), .DW(CNT_W)) u_ram (
    .iClk    (iClk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rd_data)
  );

  // A write landing on the edge that reads the same bin is captured here, since
  // the RAM would hand back the stale value.
  assign w_q       = r_fwd_vld ? r_fwd_data : w_rd_data;
  assign w_next    = (w_q == CNT_MAX) ? CNT_MAX : w_q + CNT_W'(1);
  assign w_fwd_hit = w_we && (w_waddr == w_raddr);

  // FSM state and sweep address
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_CLEAR;
      r_addr  <= {PIX_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Next state, request acceptance and RAM port steering
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_inc_acc   = 1'b0;
    w_rd_acc    = 1'b0;
    w_clr       = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_s1_addr;
    w_wdata     = w_next;
    if (bus.iInc) begin
      w_raddr = bus.iGray;
    end else begin
      w_raddr = bus.iRdAddr;
    end
    case (r_state)
      ST_IDLE: begin
        w_we = r_s1_vld;
        if (bus.iClear) begin
          w_state_nxt = ST_CLEAR;
          w_addr_nxt  = {PIX_W{1'b0}};
          w_clr       = 1'b1;
        end else begin
          w_inc_acc = bus.iInc;
          w_rd_acc  = bus.iRdEn && !bus.iInc;
        end
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_addr;
        w_wdata = {CNT_W{1'b0}};
        if (bus.iClear) begin
          w_addr_nxt = {PIX_W{1'b0}};
          w_clr      = 1'b1;
        end else if (r_addr == ADDR_LAST) begin
          w_state_nxt = ST_IDLE;
          w_addr_nxt  = {PIX_W{1'b0}};
        end else begin
          w_addr_nxt = r_addr + PIX_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_addr_nxt  = {PIX_W{1'b0}};
        w_clr       = 1'b1;
      end
    endcase
  end

  // Increment pipeline and readout registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_s1_vld     <= 1'b0;
      r_s1_addr    <= {PIX_W{1'b0}};
      r_fwd_vld    <= 1'b0;
      r_fwd_data   <= {CNT_W{1'b0}};
      r_rd_vld     <= 1'b0;
      r_gray       <= {PIX_W{1'b0}};
      r_histo_hold <= {CNT_W{1'b0}};
      r_busy       <= 1'b1;
    end else begin
      r_s1_vld   <= w_inc_acc;
      r_fwd_vld  <= (w_inc_acc || w_rd_acc) && w_fwd_hit;
      r_fwd_data <= w_wdata;
      r_rd_vld   <= w_rd_acc;
      r_busy     <= (w_state_nxt == ST_CLEAR);
      if (w_inc_acc) begin
        r_s1_addr <= bus.iGray;
      end
      if (w_rd_acc) begin
        r_gray <= bus.iRdAddr;
      end
      if (r_rd_vld) begin
        r_histo_hold <= w_q;
      end
    end
  end

  // Frame total and sticky saturation flag; a clear overrides both
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_total <= {TOT_W{1'b0}};
      r_sat   <= 1'b0;
    end else if (w_clr) begin
      r_total <= {TOT_W{1'b0}};
      r_sat   <= 1'b0;
    end else begin
      if (w_inc_acc && (r_total != TOT_MAX)) begin
        r_total <= r_total + TOT_W'(1);
      end
      if (r_s1_vld && (w_next == CNT_MAX)) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign bus.oRdValid   = r_rd_vld;
  assign bus.oGray      = r_gray;
  assign bus.oGrayHisto = r_rd_vld ? w_q : r_histo_hold;
  assign bus.oTotal     = r_total;
  assign bus.oBusy      = r_busy;
  assign bus.oSat       = r_sat;
endmodule
